md_ctrl: RTL and testbench

- Sequencing controller for the EX-stage multiply/divide resource and its HI/LO register pair.
- Accepts mult/div/mthi/mtlo operations from EX and launches them into a fixed-latency datapath sub-module.
- Counts the operation latency, commits results to HI/LO, and generates the busy/stall signals the hazard unit uses to hold md-class instructions in D.
- Honours the exception/interrupt request: an operation is suppressed in the cycle it is flushed, but an in-flight operation always completes.

---
 rtl/md_ctrl_pkg.sv | 34 +++
 rtl/md_datapath.sv | 46 ++++
 rtl/md_ctrl.sv | 124 ++++++++++++
 tb/tb_md_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide controller.
package md_ctrl_pkg;

   // EX-stage md operation encoding; 7 behaves as NONE.
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;
   localparam int CNT_W_DEF    = 4;

   // Ops that occupy the multi-cycle datapath.
   function automatic logic is_start(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational multiply/divide result from the latched op and operands.
// Signed divide is done on magnitudes so 0x80000000 / -1 falls out as
// quotient 0x80000000, remainder 0 without a special case.
module md_datapath
   import md_ctrl_pkg::*;
(
   input  md_op_e      op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [63:0] result_o,
   output logic        div_by_zero_o
);

   logic [63:0] rs_sx, rt_sx, prod_s, prod_u;
   logic        sgn_div;
   logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

   assign rs_sx  = {{32{rs_i[31]}}, rs_i};
   assign rt_sx  = {{32{rt_i[31]}}, rt_i};
   assign prod_s = rs_sx * rt_sx;
   assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

   assign sgn_div = (op_i == MD_DIV);
   assign a_mag   = (sgn_div && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
   assign b_mag   = (sgn_div && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
   // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
   assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag   = a_mag / b_safe;
   assign r_mag   = a_mag % b_safe;
   assign quot    = (sgn_div && (rs_i[31] ^ rt_i[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem     = (sgn_div && rs_i[31]) ? (32'd0 - r_mag) : r_mag;

   assign div_by_zero_o = is_div(op_i) && (rt_i == 32'd0);

   // Select the 64-bit {hi,lo} result for the latched op.
   always_comb begin
      result_o = '0;
      case (op_i)
         MD_MULT:          result_o = prod_s;
         MD_MULTU:         result_o = prod_u;
         MD_DIV, MD_DIVU:  result_o = {rem, quot};
         default:          result_o = '0;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Sequencing controller for the EX-stage multiply/divide unit and HI/LO.
// Launches ops into md_datapath, counts the fixed latency, commits HI/LO
// and raises busy/stall for the hazard unit.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   if ((1 << CNT_W) <= ((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT)) begin : g_cnt_w_check
      $error("md_ctrl: CNT_W too small for the configured latencies");
   end

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_op_e           op_q, op_d;
   logic [31:0]      rs_q, rs_d, rt_q, rt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;

   md_op_e      op_in;
   logic        accept;
   logic [63:0] dp_result;
   logic        dp_div_by_zero;

   assign op_in = md_op_e'(md_op);

   md_datapath u_datapath (
      .op_i          (op_q),
      .rs_i          (rs_q),
      .rt_i          (rt_q),
      .result_o      (dp_result),
      .div_by_zero_o (dp_div_by_zero)
   );

   // Next-state: accept/MTHI/MTLO in IDLE, count down and commit in RUN.
   always_comb begin
      // NOTE: every _d takes its hold value first so no branch can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!req) begin
               if (is_start(op_in)) begin
                  accept  = 1'b1;
                  state_d = ST_RUN;
                  op_d    = op_in;
                  rs_d    = rs_val;
                  rt_d    = rt_val;
                  cnt_d   = is_div(op_in) ? DIV_CNT : MULT_CNT;
               end else if (op_in == MD_MTHI) begin
                  hi_d = rs_val;
               end else if (op_in == MD_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         ST_RUN: begin
            // req and new ops are ignored here: the in-flight op has already left EX.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               op_d    = MD_NONE;
               if (!dp_div_by_zero) begin
                  hi_d = dp_result[63:32];
                  lo_d = dp_result[31:0];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter, latched operands and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NONE;
         rs_q    <= '0;
         rt_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign stall = d_is_md & (busy | accept);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, arithmetic corner cases, flush and reset.
module tb_md_ctrl;
   import md_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [2:0]  md_op;
   logic [31:0] rs_val, rt_val;
   logic        d_is_md;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   md_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .md_op   (md_op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   // The hazard unit never presents a start/MTHI/MTLO while busy; flag it if the bench does.
   always @(negedge clk) begin
      if (reset && busy && (md_op inside {[3'd1:3'd6]})) begin
         $display("FAIL op_in_run: md_op=%0d presented while busy", md_op);
         n_mis++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic r);
      md_op = op; rs_val = a; rt_val = b; req = r;
   endtask

   task automatic idle_in();
      md_op = MD_NONE; req = 1'b0;
   endtask

   // Issue one op, then let it run for lat cycles; ends in cycle T+lat+1.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat);
      issue(op, a, b, 1'b0);
      step();
      idle_in();
      for (int i = 0; i < lat; i++) step();
   endtask

   task automatic test_reset();
      reset = 1'b0; d_is_md = 1'b1; rs_val = '0; rt_val = '0; idle_in();
      #3;
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_mis++; end
      n_cmp++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_mis++; end
      n_cmp++; if (hi !== 32'h0) begin $display("FAIL reset_hi: got %h want 0", hi); n_mis++; end
      n_cmp++; if (lo !== 32'h0) begin $display("FAIL reset_lo: got %h want 0", lo); n_mis++; end
      step(); step();
      reset = 1'b1; d_is_md = 1'b0;
      step();
   endtask

   task automatic test_mult();
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      #1;
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL mult_busy_T: got %b want 0", busy); n_mis++; end
      step();
      idle_in();
      for (int i = 1; i <= 5; i++) begin
         n_cmp++; if (busy !== 1'b1) begin $display("FAIL mult_busy_T+%0d: got %b want 1", i, busy); n_mis++; end
         if (i == 5) begin
            n_cmp++; if (hi !== 32'h0) begin $display("FAIL mult_early_hi: got %h want 0", hi); n_mis++; end
         end
         step();
      end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL mult_busy_T+6: got %b want 0", busy); n_mis++; end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin $display("FAIL mult_hi: got %h want ffffffff", hi); n_mis++; end
      n_cmp++; if (lo !== 32'hFFFF_FFFA) begin $display("FAIL mult_lo: got %h want fffffffa", lo); n_mis++; end
   endtask

   task automatic test_multu();
      run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
      n_cmp++; if (hi !== 32'h0000_0002) begin $display("FAIL multu_hi: got %h want 00000002", hi); n_mis++; end
      n_cmp++; if (lo !== 32'hFFFF_FFFA) begin $display("FAIL multu_lo: got %h want fffffffa", lo); n_mis++; end
   endtask

   task automatic test_divu_stall();
      d_is_md = 1'b1;
      issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
      #1;
      n_cmp++; if (stall !== 1'b1) begin $display("FAIL divu_stall_T: got %b want 1", stall); n_mis++; end
      step();
      idle_in();
      for (int i = 1; i <= 10; i++) begin
         n_cmp++;
         if ({busy, stall} !== 2'b11) begin
            $display("FAIL divu_busy_stall_T+%0d: got %b%b want 11", i, busy, stall); n_mis++;
         end
         step();
      end
      n_cmp++; if ({busy, stall} !== 2'b00) begin $display("FAIL divu_T+11: got busy/stall %b%b want 00", busy, stall); n_mis++; end
      n_cmp++; if (hi !== 32'd2) begin $display("FAIL divu_hi: got %h want 00000002", hi); n_mis++; end
      n_cmp++; if (lo !== 32'd14) begin $display("FAIL divu_lo: got %h want 0000000e", lo); n_mis++; end
      d_is_md = 1'b0;
   endtask

   task automatic test_div_signed();
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      n_cmp++; if (lo !== 32'h8000_0000) begin $display("FAIL div_ovf_lo: got %h want 80000000", lo); n_mis++; end
      n_cmp++; if (hi !== 32'h0) begin $display("FAIL div_ovf_hi: got %h want 00000000", hi); n_mis++; end
      // -7 / 2 -> quotient -3, remainder -1
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin $display("FAIL div_neg_lo: got %h want fffffffd", lo); n_mis++; end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin $display("FAIL div_neg_hi: got %h want ffffffff", hi); n_mis++; end
   endtask

   task automatic test_div_zero();
      issue(MD_MTHI, 32'h11, 32'd0, 1'b0); step();
      issue(MD_MTLO, 32'h22, 32'd0, 1'b0); step();
      idle_in();
      n_cmp++; if ({hi, lo} !== {32'h11, 32'h22}) begin $display("FAIL dz_setup: got %h/%h want 11/22", hi, lo); n_mis++; end
      issue(MD_DIV, 32'd5, 32'd0, 1'b0);
      step();
      idle_in();
      for (int i = 1; i <= 10; i++) begin
         n_cmp++; if (busy !== 1'b1) begin $display("FAIL dz_busy_T+%0d: got %b want 1", i, busy); n_mis++; end
         step();
      end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL dz_busy_end: got %b want 0", busy); n_mis++; end
      n_cmp++; if ({hi, lo} !== {32'h11, 32'h22}) begin $display("FAIL dz_hilo: got %h/%h want 11/22", hi, lo); n_mis++; end
   endtask

   task automatic test_req_flush();
      d_is_md = 1'b1;
      issue(MD_MULTU, 32'd5, 32'd6, 1'b1);
      #1;
      n_cmp++; if (stall !== 1'b0) begin $display("FAIL flush_stall: got %b want 0", stall); n_mis++; end
      step();
      idle_in();
      d_is_md = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL flush_busy: got %b want 0", busy); n_mis++; end
      step();
      n_cmp++; if ({hi, lo} !== {32'h11, 32'h22}) begin $display("FAIL flush_hilo: got %h/%h want 11/22", hi, lo); n_mis++; end
      // 7 * -2 = -14; req arrives mid-run and must not disturb it
      issue(MD_MULT, 32'd7, 32'hFFFF_FFFE, 1'b0);
      step();                      // T+1
      idle_in();
      step(); req = 1'b1;          // T+2
      step(); req = 1'b0;          // T+3
      step(); step();              // T+5
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL req_run_busy_T+5: got %b want 1", busy); n_mis++; end
      step();                      // T+6
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL req_run_busy_T+6: got %b want 0", busy); n_mis++; end
      n_cmp++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFF2}) begin
         $display("FAIL req_run_hilo: got %h/%h want ffffffff/fffffff2", hi, lo); n_mis++;
      end
   endtask

   task automatic test_mthi_mtlo();
      issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
      step();
      idle_in();
      n_cmp++; if (hi !== 32'hDEAD_BEEF) begin $display("FAIL mthi_hi: got %h want deadbeef", hi); n_mis++; end
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL mthi_busy: got %b want 0", busy); n_mis++; end
      issue(MD_MTLO, 32'h1234_5678, 32'd0, 1'b1);
      step();
      idle_in();
      n_cmp++; if (lo !== 32'hFFFF_FFF2) begin $display("FAIL mtlo_req_lo: got %h want fffffff2", lo); n_mis++; end
      issue(MD_MTLO, 32'h0BAD_F00D, 32'd0, 1'b0);
      step();
      idle_in();
      n_cmp++; if (lo !== 32'h0BAD_F00D) begin $display("FAIL mtlo_lo: got %h want 0badf00d", lo); n_mis++; end
      n_cmp++; if (hi !== 32'hDEAD_BEEF) begin $display("FAIL mtlo_hi_kept: got %h want deadbeef", hi); n_mis++; end
   endtask

   task automatic test_async_reset();
      issue(MD_DIV, 32'd100, 32'd3, 1'b0);
      step();                      // T+1
      idle_in();
      step(); step();              // T+3
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL arst_busy: got %b want 0", busy); n_mis++; end
      n_cmp++; if ({hi, lo} !== 64'h0) begin $display("FAIL arst_hilo: got %h/%h want 0/0", hi, lo); n_mis++; end
      step();
      reset = 1'b1;
      step();
      n_cmp++; if (busy !== 1'b0) begin $display("FAIL arst_idle: got %b want 0", busy); n_mis++; end
      issue(MD_MULT, 32'd2, 32'd3, 1'b0);
      step();
      idle_in();
      n_cmp++; if (busy !== 1'b1) begin $display("FAIL arst_mult_busy: got %b want 1", busy); n_mis++; end
      for (int i = 0; i < 5; i++) step();
      n_cmp++; if ({hi, lo} !== {32'd0, 32'd6}) begin $display("FAIL arst_mult_hilo: got %h/%h want 0/6", hi, lo); n_mis++; end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_divu_stall();
      test_div_signed();
      test_div_zero();
      test_req_flush();
      test_mthi_mtlo();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
